sc_fetch_unit: RTL and testbench
================================

// Module: sc_fetch_unit
// PURPOSE
//  Instruction-fetch stage that feeds the single-cycle processor controller.
//  Holds the PC and fetches one instruction word per step from a variable-latency instruction memory.
//  Presents the word to decode/controller for exactly one execute cycle.
//  Commits the next PC chosen by the controller's pcSel (PC+4, PC+4+imm, RS1+imm).
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  TIMEOUT_CYC   16             max wait cycles for imemAck (only with SC_FETCH_TIMEOUT_EN)
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  reset         in   1   asynchronous, active-high
//  pcSel         in   2   next-PC select from controller: 00 PC+4, 01 PC+4+imm, 10 RS1+imm
//  imm           in   16  immediate from controller, signed
//  rs1Val        in   32  register-file read-port-0 data (JAL base)
//  stall         in   1   hold execute cycle; no PC commit while high
//  imemReq       out  1   fetch request to instruction memory
//  imemAddr      out  32  fetch address (= pc)
//  imemRdata     in   32  instruction data, valid when imemAck=1
//  imemAck       in   1   memory acknowledge, one-cycle pulse
//  instruction   out  32  latched instruction word to controller
//  instrValid    out  1   high during execute cycle(s); controller outputs are meaningful
//  pc            out  32  address of the current instruction
//  pcPlus4       out  32  pc + 4 (regFileWrSel PC4 source)
//  fetchErr      out  1   sticky fetch timeout flag (0 when macro absent)
// BEHAVIOUR
//  Reset values: pc=RESET_PC, instruction=0, instrValid=0, imemReq=0, fetchErr=0, state=IDLE.
//  FSM states and transitions:
//   IDLE  -> FETCH after one cycle (first cycle after reset deassert is quiet).
//   FETCH -> imemReq=1, imemAddr=pc, held stable until imemAck.
//            On imemAck: latch imemRdata into instruction, go to EXEC.
//   EXEC  -> instrValid=1.
//            If stall=1: stay in EXEC, pc and instruction unchanged.
//            If stall=0: pc<=nextPc, go to FETCH.
//   HALT  -> entered only on timeout; all outputs idle, leave only via reset.
//  Latency: minimum 2 cycles per instruction (ack in first FETCH cycle, then one EXEC cycle).
//  imemAck with imemReq=0 is ignored.
//  Next-PC arithmetic:
//   offs = sext(imm) << 2.
//   00 -> pc+4; 01 -> pc+4+offs; 10 -> rs1Val+offs; 11 -> pc+4 (invalid select, treated as sequential).
//   All sums are 32-bit modulo: wrap past 32'hFFFF_FFFC to 0, no flag.
//  pc[1:0] are forced to 00 on every commit (JAL target is word-aligned by truncation).
//  pcSel, imm and rs1Val are sampled only on the EXEC cycle with stall=0.
//  Reset asserted mid-FETCH or mid-EXEC: immediate return to reset values; a pending ack is dropped.
// CONFIGURATION
//  SC_FETCH_TIMEOUT_EN defined:
//   - wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
//   - Reaching TIMEOUT_CYC sets fetchErr=1 and enters HALT.
//   - An ack arriving in the same cycle the count reaches TIMEOUT_CYC wins: no error.
//  SC_FETCH_TIMEOUT_EN undefined: no counter, FETCH waits indefinitely, fetchErr tied 0.
// STRUCTURE
//  Shared package sc_proc_pkg:
//   - pcSel encodings PCSEL_4/PCSEL_4IMM/PCSEL_RS1IMM
//   - FSM state typedef
//   - RESET_PC default
//  Sub-module sc_next_pc: combinational next-PC adder/mux (pc, pcSel, imm, rs1Val -> nextPc).
// TESTING
//  1. Reset release, 0-wait memory, pcSel=00: imemAddr sequence 0,4,8,C; instrValid every 2nd cycle.
//  2. Branch at pc=0x10, pcSel=01, imm=16'hFFFE: next imemAddr = 0x0C.
//  3. JAL, rs1Val=0x103, imm=1, pcSel=10: next pc=0x104 (low bits cleared).
//  4. stall=1 for 3 EXEC cycles: pc/instruction stable, single commit after stall drops.
//  5. 5-cycle ack latency with reset pulsed on cycle 3: pc=RESET_PC, late ack ignored.
//  6. (SC_FETCH_TIMEOUT_EN) no ack for 16 cycles: fetchErr=1, imemReq=0 until reset.

Source files
------------

// File: rtl/sc_proc_pkg.sv
// Shared types and constants for the single-cycle processor fetch path.
// Next-PC select encodings, fetch FSM state type, default reset PC.
package sc_proc_pkg;

    localparam logic [1:0] PCSEL_4      = 2'b00;
    localparam logic [1:0] PCSEL_4IMM   = 2'b01;
    localparam logic [1:0] PCSEL_RS1IMM = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } fetch_state_e;

    // Word offset: sign-extended immediate scaled by 4.
    function automatic logic [31:0] imm_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/sc_next_pc.sv
// Combinational next-PC selector: PC+4, PC+4+imm*4 or RS1+imm*4, all modulo 2^32.
module sc_next_pc
    import sc_proc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcSel,
    input  logic [15:0] imm,
    input  logic [31:0] rs1Val,
    output logic [31:0] nextPc
);

    logic [31:0] pc_plus4;
    logic [31:0] offs;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        offs     = imm_offset(imm);
        case (pcSel)
            PCSEL_4IMM:   nextPc = pc_plus4 + offs;
            PCSEL_RS1IMM: nextPc = rs1Val + offs;
            default:      nextPc = pc_plus4;  // 2'b11 falls back to sequential
        endcase
    end

endmodule

// File: rtl/sc_fetch_unit.sv
// Instruction fetch stage: PC register, variable-latency imem handshake, one-word hold for execute.
// Optional fetch timeout with sticky fetchErr and HALT state: define SC_FETCH_TIMEOUT_EN.
module sc_fetch_unit
    import sc_proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pcSel,
    input  logic [15:0] imm,
    input  logic [31:0] rs1Val,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemAck,
    output logic [31:0] instruction,
    output logic        instrValid,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        fetchErr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;

`ifdef SC_FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYC - 1);
    logic [CntW-1:0] wait_q, wait_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    sc_next_pc u_next_pc (
        .pc     (pc_q),
        .pcSel  (pcSel),
        .imm    (imm),
        .rs1Val (rs1Val),
        .nextPc (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        imemReq    = 1'b0;
        instrValid = 1'b0;
`ifdef SC_FETCH_TIMEOUT_EN
        wait_d     = '0;  // any state other than FETCH rearms the counter
        err_d      = err_q;
`endif
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    instr_d = imemRdata;
                    state_d = StExec;
                end
`ifdef SC_FETCH_TIMEOUT_EN
                else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            StExec: begin
                instrValid = 1'b1;
                if (!stall) begin
                    pc_d    = {next_pc[31:2], 2'b00};
                    state_d = StFetch;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef SC_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end
    assign fetchErr = err_q;
`else
    assign fetchErr = 1'b0;
`endif

    assign imemAddr    = pc_q;
    assign pc          = pc_q;
    assign pcPlus4     = pc_q + 32'd4;
    assign instruction = instr_q;

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Self-checking bench for sc_fetch_unit: directed scenarios plus randomized fetch/execute traffic.
// Timeout scenario is compiled in only when SC_FETCH_TIMEOUT_EN is defined.
module tb_sc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pcSel;
    logic [15:0] imm;
    logic [31:0] rs1Val;
    logic        stall;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemAck;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        fetchErr;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    sc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcSel       (pcSel),
        .imm         (imm),
        .rs1Val      (rs1Val),
        .stall       (stall),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemRdata   (imemRdata),
        .imemAck     (imemAck),
        .instruction (instruction),
        .instrValid  (instrValid),
        .pc          (pc),
        .pcPlus4     (pcPlus4),
        .fetchErr    (fetchErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule: signed word offset, 32-bit wrap, word alignment.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                               input logic [15:0] im, input logic [31:0] rs1);
        int          off;
        logic [31:0] t;
        off = 4 * int'($signed(im));
        if (sel == 2'd1)      t = cur + 32'd4 + off;
        else if (sel == 2'd2) t = rs1 + off;
        else                  t = cur + 32'd4;
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic wait_req();
        int k = 0;
        while (imemReq !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        check("req_seen", 32'(imemReq), 32'd1);
    endtask

    task automatic do_instr(input int lat, input logic [31:0] data, input int nstall,
                            input logic [1:0] sel, input logic [15:0] im, input logic [31:0] rs1);
        wait_req();
        check("fetch_addr", imemAddr, exp_pc);
        check("fetch_valid", 32'(instrValid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            imemAck   = 1'b0;
            imemRdata = $urandom;
            step();
            check("addr_hold", imemAddr, exp_pc);
            check("req_hold", 32'(imemReq), 32'd1);
        end
        imemAck   = 1'b1;
        imemRdata = data;
        step();
        imemAck = 1'b0;
        check("exec_valid", 32'(instrValid), 32'd1);
        check("exec_instr", instruction, data);
        check("exec_pc", pc, exp_pc);
        check("exec_pc4", pcPlus4, exp_pc + 32'd4);
        check("exec_noreq", 32'(imemReq), 32'd0);
        for (int s = 0; s < nstall; s++) begin
            stall     = 1'b1;
            pcSel     = 2'($urandom);
            imm       = 16'($urandom);
            rs1Val    = $urandom;
            imemAck   = 1'($urandom);
            imemRdata = $urandom;
            step();
            check("stall_valid", 32'(instrValid), 32'd1);
            check("stall_instr", instruction, data);
            check("stall_pc", pc, exp_pc);
        end
        stall     = 1'b0;
        pcSel     = sel;
        imm       = im;
        rs1Val    = rs1;
        imemAck   = 1'($urandom);  // must be ignored outside FETCH
        imemRdata = $urandom;
        step();
        exp_pc    = model_next(exp_pc, sel, im, rs1);
        imemAck   = 1'b0;
        pcSel     = 2'($urandom);
        imm       = 16'($urandom);
        rs1Val    = $urandom;
        check("commit_pc", pc, exp_pc);
        check("commit_instr", instruction, data);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_pc = 32'h0;
        check("idle_quiet", 32'(imemReq), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset     = 1'b1;
        pcSel     = '0;
        imm       = '0;
        rs1Val    = '0;
        stall     = 1'b0;
        imemAck   = 1'b0;
        imemRdata = '0;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_err", 32'(fetchErr), 32'd0);
        reset  = 1'b0;
        exp_pc = 32'h0;
        check("idle_quiet", 32'(imemReq), 32'd0);

        // Sequential zero-wait fetches: 0,4,8,C, then branch back from 0x10.
        for (int i = 0; i < 4; i++) do_instr(0, $urandom, 0, 2'b00, 16'($urandom), $urandom);
        check("seq_pc10", pc, 32'h10);
        do_instr(0, $urandom, 0, 2'b01, 16'hFFFE, $urandom);
        wait_req();
        check("branch_addr", imemAddr, 32'h0C);
        do_instr(1, $urandom, 0, 2'b10, 16'h0001, 32'h0000_0103);
        check("jal_pc", pc, 32'h104);
        do_instr(0, $urandom, 3, 2'b00, 16'h0, 32'h0);
        check("stall_commit", pc, 32'h108);

        // Reset during a 5-cycle-latency fetch; the late ack lands in the quiet cycle.
        wait_req();
        imemAck = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_req", 32'(imemReq), 32'd0);
        check("midrst_instr", instruction, 32'h0);
        step();
        reset     = 1'b0;
        exp_pc    = 32'h0;
        imemAck   = 1'b1;
        imemRdata = 32'hDEAD_BEEF;
        step();
        imemAck = 1'b0;
        check("late_ack_valid", 32'(instrValid), 32'd0);
        check("late_ack_instr", instruction, 32'h0);
        check("late_ack_req", 32'(imemReq), 32'd1);
        check("late_ack_addr", imemAddr, 32'h0);

        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            do_instr(int'($urandom_range(0, 4)), d, int'($urandom_range(0, 2)),
                     2'($urandom), 16'($urandom), $urandom);
        end

`ifdef SC_FETCH_TIMEOUT_EN
        apply_reset();
        wait_req();
        for (int i = 1; i < 16; i++) begin
            step();
            check("to_req", 32'(imemReq), 32'd1);
            check("to_noerr", 32'(fetchErr), 32'd0);
        end
        step();
        check("to_err", 32'(fetchErr), 32'd1);
        check("to_halt_req", 32'(imemReq), 32'd0);
        imemAck = 1'b1;
        step();
        step();
        imemAck = 1'b0;
        check("halt_err", 32'(fetchErr), 32'd1);
        check("halt_req", 32'(imemReq), 32'd0);
        check("halt_valid", 32'(instrValid), 32'd0);
        apply_reset();
        check("to_clear", 32'(fetchErr), 32'd0);
        do_instr(2, $urandom, 0, 2'b00, 16'h0, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
